// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, round-key slot type, Rcon table,
// key-expansion state encoding and the RotWord helper.
package aes_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_KEY_W = 128;
   localparam int RK_BUS_W  = AES_KEY_W * (AES_NR + 1);

   typedef logic [AES_KEY_W-1:0] round_key_t;
   typedef logic [31:0]          word_t;
   typedef logic [3:0]           round_idx_t;

   localparam round_idx_t LAST_ROUND = 4'(AES_NR);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } kx_state_t;

   // Entry 0 is unused by the schedule; it is the value seen outside BUSY.
   localparam logic [7:0] RCON [0:AES_NR] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Cyclic left rotation by one byte: {a,b,c,d} -> {b,c,d,a}.
   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
   input  logic [7:0] value,
   output logic [7:0] subst
);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign subst = SBOX[value];

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: one round key per clock, 11 round keys held on a
// flat 1408-bit bus. Optional combinational round-key read port enabled by
// the KEY_EXPANSION_RDPORT_EN macro.
module key_expansion
   import aes_pkg::*;
(
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iKeyValid,
   input  logic [AES_KEY_W-1:0] iKey,
`ifdef KEY_EXPANSION_RDPORT_EN
   input  logic [3:0]           iRoundSel,
   output logic [AES_KEY_W-1:0] oRoundKey,
`endif
   output logic [RK_BUS_W-1:0]  oRoundKeys,
   output logic                 oBusy,
   output logic                 oValid
);

   kx_state_t  state, state_next;
   round_idx_t round;
   round_idx_t prev_idx;
   round_key_t slots [0:AES_NR];
   round_key_t prev_key, next_key;
   word_t      w0, w1, w2, w3;
   word_t      n0, n1, n2, n3;
   word_t      rot, sub, temp;
   logic [7:0] rcon_byte;

   // Select the previous slot and the round constant for the current round.
   always_comb begin
      prev_idx = round - 4'd1;
      if (prev_idx > LAST_ROUND) prev_idx = '0;
      prev_key  = slots[prev_idx];
      rcon_byte = (round <= LAST_ROUND) ? RCON[round] : 8'h00;
   end

   assign {w0, w1, w2, w3} = prev_key;
   assign rot = rot_word(w3);

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .value (rot[8*b +: 8]),
         .subst (sub[8*b +: 8])
      );
   end

   // Round function: chained XOR of the previous words with the core temp word.
   always_comb begin
      temp     = sub ^ {rcon_byte, 24'h0};
      n0       = w0 ^ temp;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   // State register with synchronous reset.
   always_ff @(posedge iClk) begin
      if (iRst) state <= ST_IDLE;
      else      state <= state_next;
   end

   // Next-state logic: a key strobe always (re)starts; BUSY ends after slot 10.
   always_comb begin
      state_next = state;
      if (iKeyValid) begin
         state_next = ST_BUSY;
      end else begin
         case (state)
            ST_BUSY: if (round == LAST_ROUND) state_next = ST_DONE;
            default: state_next = state;
         endcase
      end
   end

   // Slot array and round counter. Reset has priority over a key strobe.
   // NOTE: the slot array is explicitly cleared on reset because consumers can
   // observe the bus at any time; this keeps the storage in resettable flops.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         for (int i = 0; i <= AES_NR; i++) slots[i] <= '0;
         round <= '0;
      end else if (iKeyValid) begin
         slots[0] <= iKey;
         for (int i = 1; i <= AES_NR; i++) slots[i] <= '0;
         round <= 4'd1;
      end else if (state == ST_BUSY) begin
         slots[round] <= next_key;
         round        <= round + 4'd1;
      end
   end

   assign oBusy  = (state == ST_BUSY);
   assign oValid = (state == ST_DONE);

   for (genvar g = 0; g <= AES_NR; g++) begin : g_flat
      assign oRoundKeys[AES_KEY_W*g +: AES_KEY_W] = slots[g];
   end

`ifdef KEY_EXPANSION_RDPORT_EN
   // Combinational read port; selectors beyond the last round read zero.
   always_comb begin
      oRoundKey = '0;
      if (iRoundSel <= LAST_ROUND) oRoundKey = slots[iRoundSel];
   end
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Directed self-checking bench for key_expansion using FIPS-197 vectors.
// Exercises the read port when KEY_EXPANSION_RDPORT_EN is defined.
module tb_key_expansion;

   logic          iClk;
   logic          iRst;
   logic          iKeyValid;
   logic [127:0]  iKey;
   logic [1407:0] oRoundKeys;
   logic          oBusy;
   logic          oValid;
`ifdef KEY_EXPANSION_RDPORT_EN
   logic [3:0]    iRoundSel;
   logic [127:0]  oRoundKey;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_Z = 128'h0;

   key_expansion dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iKeyValid  (iKeyValid),
      .iKey       (iKey),
`ifdef KEY_EXPANSION_RDPORT_EN
      .iRoundSel  (iRoundSel),
      .oRoundKey  (oRoundKey),
`endif
      .oRoundKeys (oRoundKeys),
      .oBusy      (oBusy),
      .oValid     (oValid)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rk(input int i);
      return oRoundKeys[128*i +: 128];
   endfunction

   // Present a key for exactly one rising edge; returns on the negedge after it.
   task automatic strobe(input logic [127:0] key);
      @(negedge iClk);
      iKey      = key;
      iKeyValid = 1'b1;
      @(negedge iClk);
      iKeyValid = 1'b0;
   endtask

   // Count edges after the accepting edge until oValid is seen (bounded).
   task automatic wait_valid(output int edges);
      edges = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge iClk);
         if (oValid) begin
            edges = n;
            break;
         end
      end
   endtask

   int lat;

   initial begin
      iRst      = 1'b1;
      iKeyValid = 1'b0;
      iKey      = '0;
`ifdef KEY_EXPANSION_RDPORT_EN
      iRoundSel = 4'd0;
`endif
      repeat (2) @(negedge iClk);
      check("reset_bus",   128'(oRoundKeys != '0), 128'd0);
      check("reset_busy",  128'(oBusy), 128'd0);
      check("reset_valid", 128'(oValid), 128'd0);
      iRst = 1'b0;

      // FIPS-197 appendix A-style key 00..0f.
      strobe(KEY_A);
      check("a_busy_start",  128'(oBusy), 128'd1);
      check("a_valid_start", 128'(oValid), 128'd0);
      check("a_rk0_early",   rk(0), KEY_A);
      check("a_rk10_early",  rk(10), 128'h0);
      wait_valid(lat);
      check("a_latency", 128'(lat), 128'd10);
      check("a_busy_done", 128'(oBusy), 128'd0);
      check("a_rk0",  rk(0),  KEY_A);
      check("a_rk1",  rk(1),  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      check("a_rk2",  rk(2),  128'hb692cf0b643dbdf1be9bc5006830b3fe);
      check("a_rk9",  rk(9),  128'h549932d1f08557681093ed9cbe2c974e);
      check("a_rk10", rk(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
`ifdef KEY_EXPANSION_RDPORT_EN
      iRoundSel = 4'd10;
      #1;
      check("rd_sel10", oRoundKey, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      iRoundSel = 4'd12;
      #1;
      check("rd_sel12", oRoundKey, 128'h0);
      iRoundSel = 4'd0;
`endif
      repeat (5) @(negedge iClk);
      check("a_hold_valid", 128'(oValid), 128'd1);
      check("a_hold_rk10",  rk(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // FIPS-197 appendix A.1 key.
      strobe(KEY_B);
      check("b_valid_cleared", 128'(oValid), 128'd0);
      wait_valid(lat);
      check("b_latency", 128'(lat), 128'd10);
      check("b_rk1",  rk(1),  128'ha0fafe1788542cb123a339392a6c7605);
      check("b_rk10", rk(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // All-zero key.
      strobe(KEY_Z);
      wait_valid(lat);
      check("z_latency", 128'(lat), 128'd10);
      check("z_rk1",  rk(1),  128'h62636363626363636263636362636363);
      check("z_rk10", rk(10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // Restart: second strobe at cycle 4 of the first expansion.
      strobe(KEY_Z);
      repeat (2) begin
         @(negedge iClk);
         check("rs_valid_low", 128'(oValid), 128'd0);
      end
      strobe(KEY_A);
      wait_valid(lat);
      check("rs_latency", 128'(lat), 128'd10);
      check("rs_rk10", rk(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
      check("rs_rk1",  rk(1),  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

      // Reset in the middle of an expansion.
      strobe(KEY_B);
      repeat (3) @(negedge iClk);
      check("mr_busy_before", 128'(oBusy), 128'd1);
      iRst = 1'b1;
      @(negedge iClk);
      iRst = 1'b0;
      check("mr_bus",   128'(oRoundKeys != '0), 128'd0);
      check("mr_busy",  128'(oBusy), 128'd0);
      check("mr_valid", 128'(oValid), 128'd0);
      repeat (12) @(negedge iClk);
      check("mr_bus_idle",   128'(oRoundKeys != '0), 128'd0);
      check("mr_valid_idle", 128'(oValid), 128'd0);
      check("mr_busy_idle",  128'(oBusy), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/key_expansion.md
Name: key_expansion

Overview:
AES-128 key schedule. Expands a 128-bit cipher key into 11 round keys (1408 bits) per FIPS-197, computing one round key per clock. Sits between the key register and the cipher/inverse-cipher datapath, which consumes the full round-key bus once oValid is high.

Parameters:
None. AES-128 only; all widths are fixed.

Ports:
iClk  in  1  clock; all state updates on the rising edge
iRst  in  1  synchronous, active-high reset
iKeyValid  in  1  single-cycle strobe: load iKey and start expansion
iKey  in  128  cipher key; byte 0 is bits [127:120]
oRoundKeys  out  1408  round key i at bits [128*i +: 128], i = 0..10
oBusy  out  1  expansion in progress
oValid  out  1  all 11 round keys on oRoundKeys are final

Behaviour:
- Reset (iRst=1 at a rising edge): oRoundKeys=0, oBusy=0, oValid=0, state IDLE, round counter=0. Reset has priority over iKeyValid.
- States:
  - IDLE: after reset.
  - BUSY: rounds 1..10 being generated.
  - DONE: holds results.
- iKeyValid=1 at an edge, in any state:
  - slot 0 <= iKey; slots 1..10 <= 0;
  - counter <= 1; oBusy <= 1; oValid <= 0; state BUSY.
  - A strobe during BUSY aborts the current expansion and restarts with the new key.
- BUSY, each edge:
  - slot r <= f(slot r-1, r); counter++.
  - At the edge writing slot 10: state DONE, oBusy <= 0, oValid <= 1.
  - Latency: oValid rises 10 edges after the accepting edge.
- DONE: outputs held; oValid stays 1 until the next iKeyValid or reset.
- Round function f(prev, r):
  - prev = {w0, w1, w2, w3}, with w0 = bits [127:96].
  - t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}.
  - RotWord: bytes {a,b,c,d} become {b,c,d,a}.
  - SubWord applies the AES S-box to each byte.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2; result = {n0, n1, n2, n3}.
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- oRoundKeys is a direct register output; no combinational path from iKey.
- Slots not yet computed read 0 while oBusy=1.

Optional Feature:
Macro KEY_EXPANSION_RDPORT_EN.
- Defined:
  - Adds input iRoundSel[3:0] and output oRoundKey[127:0] = slot iRoundSel.
  - The read port is a combinational mux.
  - iRoundSel values 11..15 return 128'h0.
- Undefined: neither port exists. All other behaviour is identical.

Decomposition:
- Shared package aes_pkg:
  - constants AES_NR=10, AES_KEY_W=128, RK_BUS_W=1408;
  - Rcon table;
  - round-key slot type (logic [127:0]).
- Sub-module aes_sbox: combinational 8-bit S-box. key_expansion instantiates 4 copies for SubWord.

Test Plan:
- Reset, then iKeyValid with key 000102030405060708090a0b0c0d0e0f.
  - Expect oValid after 10 cycles.
  - rk1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
  - rk2 = b692cf0b643dbdf1be9bc5006830b3fe.
  - rk9 = 549932d1f08557681093ed9cbe2c974e.
  - rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - rk0 equals the key.
- Key 2b7e151628aed2a6abf7158809cf4f3c:
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rk1 = 62636363626363636263636362636363.
  - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Restart: strobe the zero key, then strobe key 000102…0f at cycle 4.
  - oValid stays 0 until 10 cycles after the second strobe.
  - Final rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Reset mid-operation: assert iRst during BUSY.
  - Next cycle: oRoundKeys=0, oBusy=0, oValid=0.
  - No further updates without a new strobe.
- With KEY_EXPANSION_RDPORT_EN, after the 000102…0f expansion completes:
  - iRoundSel=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
  - iRoundSel=12 gives 0.
